regfile_2r1w_param: RTL and testbench
=====================================

Name: regfile_2r1w_param

Overview:
- Parametrised successor to the 16x32 register bank.
- Single write port with byte enables; two independent registered read ports (A, B) with write-to-read bypass.
- Optional hardwired-zero entry 0.
- Sequenced bulk-clear engine that zeroes the array one entry per cycle with busy/done handshake.
- Serves as the general-purpose register store for datapath blocks in the same design.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 0, when 1: entry 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- write_en  in  1  write request.
- write_line  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- write_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- write_ready  out  1  high when writes are accepted (= !clr_busy).
- read_en_a  in  1  read request, port A.
- read_line_a  in  ADDR_W  read address, port A.
- rdata_a  out  DATA_W  registered read data, port A.
- rvalid_a  out  1  rdata_a updated this cycle.
- read_en_b / read_line_b / rdata_b / rvalid_b: identical to port A, for port B.
- clr_req  in  1  bulk-clear request (level sampled).
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset (asynchronous, immediate on reset_n low):
  - All DEPTH entries = 0.
  - rdata_a = rdata_b = 0; rvalid_a = rvalid_b = 0.
  - clr_busy = 0, clr_done = 0, FSM = IDLE, clear counter = 0.
  - Reset during CLEAR aborts the clear; no clr_done pulse is produced.
- Write:
  - At posedge, if write_en & write_ready, each byte of entry write_line with write_be[i]=1 takes write_data byte i; other bytes are unchanged.
  - write_be = 0 is a no-op.
  - When ZERO_REG=1 and write_line = 0, the write is discarded.
  - When !write_ready, write_en is ignored; no queueing.
- Read (identical per port, ports independent):
  - Latency 1 cycle: if read_en & !clr_busy at edge N, then at N+1 rdata = entry value and rvalid = 1.
  - Bypass: a same-edge accepted write to the same line is merged byte-wise per write_be. Enabled bytes return the new data; other bytes return old data.
  - When ZERO_REG=1 and read_line = 0, rdata = 0 regardless of writes.
  - When read_en = 0 or clr_busy = 1: rvalid = 0 next cycle and rdata holds its previous value.
  - Both ports may read the same line in the same cycle.
- Clear FSM:
  - States IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req = 1; clr_busy = 1 from the next cycle; counter = 0.
  - In CLEAR, each cycle entry[counter] = 0 and counter increments.
  - At counter = DEPTH-1 that entry is cleared, then the FSM returns to IDLE. clr_busy falls and clr_done = 1 for exactly that next cycle.
  - Clear lasts exactly DEPTH cycles of clr_busy.
  - clr_req while in CLEAR is ignored. clr_req held high re-triggers a new clear from the cycle after clr_done.
  - A write accepted in the same cycle as clr_req (FSM still IDLE) completes; the subsequent clear zeroes it.
  - A read accepted in that same cycle also completes normally.
- Counter and address widths are exactly ADDR_W; the counter never wraps mid-clear.

Test Plan:
- Reset then read line 5 on A and line 15 on B -> next cycle rdata_a = rdata_b = 0x00000000, both rvalid = 1.
- Write 0xDEADBEEF to line 3 with be=4'hF, then write 0x11223344 with be=4'b0101; read line 3 -> 0xDE22BE44.
- Same-edge write of 0xCAFEF00D to line 7 (be=4'b1100) while line 7 holds 0x12345678, with port A reading line 7 -> rdata_a = 0xCAFE5678 next cycle. Port B reading line 6 is unaffected.
- ZERO_REG=1: write 0xFFFFFFFF to line 0, read line 0 -> 0x00000000.
- Fill all 16 lines with index*0x01010101, pulse clr_req:
  - clr_busy high for exactly 16 cycles, then clr_done single-cycle pulse.
  - write_en during busy is discarded; reads during busy give rvalid = 0.
  - Afterwards all lines read 0.
- Assert reset_n low at clear cycle 8 -> clr_busy = 0 immediately, no clr_done. Re-write line 12 = 0xA5A5A5A5 after release -> reads back 0xA5A5A5A5 next cycle.

Source files
------------

// File: rtl/regfile_2r1w_param_if.sv
// Bus bundle for regfile_2r1w_param: byte-enabled write port, two read ports,
// and the bulk-clear request/busy/done handshake.
interface regfile_2r1w_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  write_en;
  logic [ADDR_W-1:0]     write_line;
  logic [DATA_W-1:0]     write_data;
  logic [DATA_W/8-1:0]   write_be;
  logic                  write_ready;

  logic                  read_en_a;
  logic [ADDR_W-1:0]     read_line_a;
  logic [DATA_W-1:0]     rdata_a;
  logic                  rvalid_a;

  logic                  read_en_b;
  logic [ADDR_W-1:0]     read_line_b;
  logic [DATA_W-1:0]     rdata_b;
  logic                  rvalid_b;

  logic                  clr_req;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output write_en, write_line, write_data, write_be,
    output read_en_a, read_line_a, read_en_b, read_line_b,
    output clr_req,
    input  write_ready, rdata_a, rvalid_a, rdata_b, rvalid_b,
    input  clr_busy, clr_done
  );

  modport slave (
    input  write_en, write_line, write_data, write_be,
    input  read_en_a, read_line_a, read_en_b, read_line_b,
    input  clr_req,
    output write_ready, rdata_a, rvalid_a, rdata_b, rvalid_b,
    output clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read/1-write register file with byte enables, write-to-read
// bypass, optional hardwired-zero entry 0 and a one-entry-per-cycle bulk clear.
module regfile_2r1w_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_2r1w_param_if.slave  bus
);
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam int                NBYTES    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clr_done_q, clr_done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
  logic                rvalid_a_q, rvalid_b_q;

  logic                busy;
  logic                wr_acc;
  logic                rd_acc_a;
  logic                rd_acc_b;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NBYTES-1:0] be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic is_zero_line(input logic [ADDR_W-1:0] line);
    return ZERO_REG && (line == '0);
  endfunction

  assign busy     = (state_q == CLEAR);
  assign wr_acc   = bus.write_en && !busy && !is_zero_line(bus.write_line);
  assign rd_acc_a = bus.read_en_a && !busy;
  assign rd_acc_b = bus.read_en_b && !busy;

  assign bus.write_ready = !busy;
  assign bus.clr_busy    = busy;
  assign bus.clr_done    = clr_done_q;
  assign bus.rdata_a     = rdata_a_q;
  assign bus.rvalid_a    = rvalid_a_q;
  assign bus.rdata_b     = rdata_b_q;
  assign bus.rvalid_b    = rvalid_b_q;

  // Clear sequencer: walks every line once, then pulses done on the return to IDLE.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_LINE) begin
          state_d    = IDLE;
          clr_cnt_d  = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes are never accepted while clearing, so the two updates cannot collide.
  always_comb begin
    mem_d = mem_q;
    if (wr_acc) begin
      mem_d[bus.write_line] = byte_merge(mem_q[bus.write_line], bus.write_data, bus.write_be);
    end
    if (busy) begin
      mem_d[clr_cnt_q] = '0;
    end
  end

  always_comb begin
    rdata_a_d = rdata_a_q;
    if (rd_acc_a) begin
      if (is_zero_line(bus.read_line_a)) begin
        rdata_a_d = '0;
      end else if (wr_acc && (bus.read_line_a == bus.write_line)) begin
        rdata_a_d = byte_merge(mem_q[bus.read_line_a], bus.write_data, bus.write_be);
      end else begin
        rdata_a_d = mem_q[bus.read_line_a];
      end
    end
  end

  always_comb begin
    rdata_b_d = rdata_b_q;
    if (rd_acc_b) begin
      if (is_zero_line(bus.read_line_b)) begin
        rdata_b_d = '0;
      end else if (wr_acc && (bus.read_line_b == bus.write_line)) begin
        rdata_b_d = byte_merge(mem_q[bus.read_line_b], bus.write_data, bus.write_be);
      end else begin
        rdata_b_d = mem_q[bus.read_line_b];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rd_acc_a;
      rvalid_b_q <= rd_acc_b;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end
endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Bench for regfile_2r1w_param: drives one stimulus stream into a ZERO_REG=0 and
// a ZERO_REG=1 instance and checks both against a word-level reference model.
module tb_regfile_2r1w_param;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic          write_en    = 1'b0;
  logic [AW-1:0] write_line  = '0;
  logic [DW-1:0] write_data  = '0;
  logic [3:0]    write_be    = '0;
  logic          read_en_a   = 1'b0;
  logic [AW-1:0] read_line_a = '0;
  logic          read_en_b   = 1'b0;
  logic [AW-1:0] read_line_b = '0;
  logic          clr_req     = 1'b0;

  regfile_2r1w_param_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  regfile_2r1w_param_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  assign if0.write_en    = write_en;
  assign if0.write_line  = write_line;
  assign if0.write_data  = write_data;
  assign if0.write_be    = write_be;
  assign if0.read_en_a   = read_en_a;
  assign if0.read_line_a = read_line_a;
  assign if0.read_en_b   = read_en_b;
  assign if0.read_line_b = read_line_b;
  assign if0.clr_req     = clr_req;
  assign if1.write_en    = write_en;
  assign if1.write_line  = write_line;
  assign if1.write_data  = write_data;
  assign if1.write_be    = write_be;
  assign if1.read_en_a   = read_en_a;
  assign if1.read_line_a = read_line_a;
  assign if1.read_en_b   = read_en_b;
  assign if1.read_line_b = read_line_b;
  assign if1.clr_req     = clr_req;

  regfile_2r1w_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0)
  );
  regfile_2r1w_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1)
  );

  // Reference model: index 0 is the plain instance, index 1 the zero-entry one.
  logic [DW-1:0] mdl    [2][DEPTH];
  logic [DW-1:0] exp_ra [2];
  logic [DW-1:0] exp_rb [2];
  logic          exp_va [2];
  logic          exp_vb [2];
  int            clr_left;
  logic          exp_done;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int k, input logic [AW-1:0] line, input logic wr_ok);
    logic [DW-1:0] v;
    if (k == 1 && line == '0) return '0;
    v = mdl[k][line];
    if (wr_ok && line == write_line) begin
      for (int i = 0; i < 4; i++) begin
        if (write_be[i]) v[8*i +: 8] = write_data[8*i +: 8];
      end
    end
    return v;
  endfunction

  task automatic model_wipe();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) mdl[k][i] = '0;
  endtask

  task automatic model_reset();
    model_wipe();
    for (int k = 0; k < 2; k++) begin
      exp_ra[k] = '0; exp_rb[k] = '0; exp_va[k] = 1'b0; exp_vb[k] = 1'b0;
    end
    clr_left = 0;
    exp_done = 1'b0;
  endtask

  // Nothing can observe the array while a clear runs, so the model wipes it all
  // at the point the clear finishes.
  task automatic model_edge();
    logic busy_now, wr_ok;
    busy_now = (clr_left > 0);
    wr_ok    = write_en && !busy_now;
    for (int k = 0; k < 2; k++) begin
      exp_va[k] = read_en_a && !busy_now;
      exp_vb[k] = read_en_b && !busy_now;
      if (exp_va[k]) exp_ra[k] = model_read(k, read_line_a, wr_ok);
      if (exp_vb[k]) exp_rb[k] = model_read(k, read_line_b, wr_ok);
    end
    for (int k = 0; k < 2; k++) begin
      if (wr_ok) mdl[k][write_line] = model_read(k, write_line, 1'b1);
    end
    exp_done = 1'b0;
    if (busy_now) begin
      clr_left--;
      if (clr_left == 0) begin
        model_wipe();
        exp_done = 1'b1;
      end
    end else if (clr_req) begin
      clr_left = DEPTH;
    end
  endtask

  task automatic check_outputs();
    logic exp_busy;
    exp_busy = (clr_left > 0);
    check("z0_rdata_a",  if0.rdata_a,             exp_ra[0]);
    check("z0_rvalid_a", 32'(if0.rvalid_a),       32'(exp_va[0]));
    check("z0_rdata_b",  if0.rdata_b,             exp_rb[0]);
    check("z0_rvalid_b", 32'(if0.rvalid_b),       32'(exp_vb[0]));
    check("z0_busy",     32'(if0.clr_busy),       32'(exp_busy));
    check("z0_done",     32'(if0.clr_done),       32'(exp_done));
    check("z0_wready",   32'(if0.write_ready),    32'(!exp_busy));
    check("z1_rdata_a",  if1.rdata_a,             exp_ra[1]);
    check("z1_rvalid_a", 32'(if1.rvalid_a),       32'(exp_va[1]));
    check("z1_rdata_b",  if1.rdata_b,             exp_rb[1]);
    check("z1_rvalid_b", 32'(if1.rvalid_b),       32'(exp_vb[1]));
    check("z1_busy",     32'(if1.clr_busy),       32'(exp_busy));
    check("z1_done",     32'(if1.clr_done),       32'(exp_done));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    write_en = 1'b0; write_be = '0; read_en_a = 1'b0; read_en_b = 1'b0; clr_req = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] line, input logic [DW-1:0] data, input logic [3:0] be);
    write_en = 1'b1; write_line = line; write_data = data; write_be = be;
  endtask

  task automatic apply_reset();
    idle();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_busy_now", 32'(if0.clr_busy), 32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    int busy_cnt, done_cnt;
    #1;
    apply_reset();

    // Reads straight after reset return zero.
    read_en_a = 1'b1; read_line_a = 4'd5; read_en_b = 1'b1; read_line_b = 4'd15;
    cycle();
    check("tp_reset_rd_a", if0.rdata_a, 32'h0000_0000);
    check("tp_reset_rd_b", if0.rdata_b, 32'h0000_0000);
    check("tp_reset_rv_a", 32'(if0.rvalid_a), 32'd1);
    idle();

    // Byte-enable merge.
    do_write(4'd3, 32'hDEAD_BEEF, 4'hF); cycle();
    do_write(4'd3, 32'h1122_3344, 4'b0101); cycle();
    idle(); read_en_a = 1'b1; read_line_a = 4'd3; cycle();
    check("tp_be_merge", if0.rdata_a, 32'hDE22_BE44);
    idle();

    // Same-edge bypass on A while B reads a neighbour.
    do_write(4'd7, 32'h1234_5678, 4'hF); cycle();
    do_write(4'd6, 32'h6666_6666, 4'hF); cycle();
    do_write(4'd7, 32'hCAFE_F00D, 4'b1100);
    read_en_a = 1'b1; read_line_a = 4'd7; read_en_b = 1'b1; read_line_b = 4'd6;
    cycle();
    check("tp_bypass_a", if0.rdata_a, 32'hCAFE_5678);
    check("tp_bypass_b", if0.rdata_b, 32'h6666_6666);
    idle();

    // Hardwired-zero entry 0 (only on the ZERO_REG=1 instance).
    do_write(4'd0, 32'hFFFF_FFFF, 4'hF); cycle();
    idle(); read_en_a = 1'b1; read_line_a = 4'd0; cycle();
    check("tp_zero_reg1", if1.rdata_a, 32'h0000_0000);
    check("tp_zero_reg0", if0.rdata_a, 32'hFFFF_FFFF);
    idle();

    // Full clear with writes and reads attempted while busy.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(AW'(i), DW'(i) * 32'h0101_0101, 4'hF); cycle();
    end
    idle(); clr_req = 1'b1; cycle();
    busy_cnt = int'(if0.clr_busy); done_cnt = int'(if0.clr_done);
    clr_req = 1'b0;
    do_write(4'd2, 32'h5A5A_5A5A, 4'hF); read_en_a = 1'b1; read_en_b = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      busy_cnt += int'(if0.clr_busy); done_cnt += int'(if0.clr_done);
    end
    idle(); cycle();
    busy_cnt += int'(if0.clr_busy); done_cnt += int'(if0.clr_done);
    check("tp_busy_cycles", 32'(busy_cnt), 32'd16);
    check("tp_done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      read_en_a = 1'b1; read_line_a = AW'(i); read_en_b = 1'b1; read_line_b = AW'(DEPTH - 1 - i);
      cycle();
      check("tp_cleared_a", if0.rdata_a, 32'h0);
      check("tp_cleared_b", if0.rdata_b, 32'h0);
    end
    idle();

    // Reset in the middle of a clear aborts it without a done pulse.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(AW'(i), ~(DW'(i)), 4'hF); cycle();
    end
    idle(); clr_req = 1'b1; cycle();
    clr_req = 1'b0;
    repeat (7) cycle();
    apply_reset();
    cycle();
    check("tp_abort_no_done", 32'(if0.clr_done), 32'd0);
    do_write(4'd12, 32'hA5A5_A5A5, 4'hF); cycle();
    idle(); read_en_a = 1'b1; read_line_a = 4'd12; read_en_b = 1'b1; read_line_b = 4'd13;
    cycle();
    check("tp_after_abort", if0.rdata_a, 32'hA5A5_A5A5);
    check("tp_abort_wiped", if0.rdata_b, 32'h0);
    idle();

    // clr_req held high retriggers back to back.
    clr_req = 1'b1;
    repeat (40) cycle();
    clr_req = 1'b0;
    repeat (20) cycle();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      write_en    = 1'($urandom_range(0, 1));
      write_line  = AW'($urandom_range(0, DEPTH - 1));
      write_data  = $urandom;
      write_be    = 4'($urandom_range(0, 15));
      read_en_a   = 1'($urandom_range(0, 1));
      read_en_b   = 1'($urandom_range(0, 1));
      read_line_a = ($urandom_range(0, 2) == 0) ? write_line : AW'($urandom_range(0, DEPTH - 1));
      read_line_b = ($urandom_range(0, 2) == 0) ? write_line : AW'($urandom_range(0, DEPTH - 1));
      clr_req     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle();
    repeat (20) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
